// File: rtl/reg_file_param.sv
// Parametrised register file: one write port, two combinational read ports, optional
// hardwired zero register, optional write-to-read bypass and a one-entry-per-cycle clear sweep.
module reg_file_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we3,
  input  logic [AW-1:0]    wa3,
  input  logic [WIDTH-1:0] wd3,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  input  logic             clr,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic             busy,
  output logic             wr_drop
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [AW-1:0]    ptr_r, ptr_s;
  logic             wr_drop_r, wr_drop_s;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             idle_s, wa_zero_s, wr_ok_s, wr_commit_s;

  // Selects one read port value; busy and the zero register override everything.
  function automatic logic [WIDTH-1:0] read_sel(
    input logic [AW-1:0]    ra,
    input logic [WIDTH-1:0] stored,
    input logic             busy_i,
    input logic             byp_i,
    input logic [AW-1:0]    wa,
    input logic [WIDTH-1:0] wd
  );
    logic [WIDTH-1:0] v;
    if (busy_i) begin
      v = '0;
    end else if ((ZERO_REG != 0) && (ra == '0)) begin
      v = '0;
    end else if ((BYPASS != 0) && byp_i && (wa == ra)) begin
      v = wd;
    end else begin
      v = stored;
    end
    return v;
  endfunction

  // Write acceptance and rejection decode.
  always_comb begin
    idle_s      = (state_r == S_IDLE);
    wa_zero_s   = (ZERO_REG != 0) && (wa3 == '0);
    wr_ok_s     = idle_s && we3 && !clr && !wa_zero_s;
    wr_commit_s = wr_ok_s && !rst;
    wr_drop_s   = we3 && (!idle_s || clr);
  end

  // Clear-sweep next-state logic; the terminal compare happens before ptr wraps.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    case (state_r)
      S_IDLE: begin
        if (clr) begin
          state_s = S_CLEAR;
          ptr_s   = '0;
        end else begin
          state_s = S_IDLE;
          ptr_s   = ptr_r;
        end
      end
      S_CLEAR: begin
        ptr_s = ptr_r + AW'(1'b1);
        if (ptr_r == AW'(DEPTH - 1)) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_CLEAR;
        end
      end
      default: begin
        state_s = S_IDLE;
        ptr_s   = '0;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_CLEAR;
      ptr_r     <= '0;
      wr_drop_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      ptr_r     <= ptr_s;
      wr_drop_r <= wr_drop_s;
    end
  end

  // Reset-less storage, zeroed by the sweep instead.
  always_ff @(posedge clk) begin
    if (state_r == S_CLEAR) begin
      mem_r[ptr_r] <= '0;
    end else if (wr_commit_s) begin
      mem_r[wa3] <= wd3;
    end
  end

  // Combinational read ports.
  always_comb begin
    rd1 = read_sel(ra1, mem_r[ra1], !idle_s, wr_ok_s, wa3, wd3);
    rd2 = read_sel(ra2, mem_r[ra2], !idle_s, wr_ok_s, wa3, wd3);
  end

  assign busy    = (state_r == S_CLEAR);
  assign wr_drop = wr_drop_r;

endmodule
